// File: rtl/sms_trigger_driver.sv
// Gate/pulse sequencer for an SMS trigger-binary card: clear/set/toggle/sense
// commands over valid/ready, then confirms the trigger reached the target.
// Ports:
//   clk, reset_left        clock, async active-high reset
//   cmd_valid/cmd_op/cmd_ready  command handshake (00 clr, 01 set, 10 tgl, 11 sense)
//   trig_b, trig_p         trigger complementary outputs (read back)
//   gate_left/right        registered gate levels
//   ac_set_left/right      registered AC-set pulses
//   done, err, state_out   one-cycle completion strobe with result
module sms_trigger_driver #(
    parameter int GATE_SETUP      = 2,
    parameter int PULSE_WIDTH     = 3,
    parameter int GATE_HOLD       = 1,
    parameter int CONFIRM_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset_left,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    input  logic       trig_b,
    input  logic       trig_p,
    output logic       gate_left,
    output logic       ac_set_left,
    output logic       gate_right,
    output logic       ac_set_right,
    output logic       done,
    output logic       err,
    output logic       state_out
);

    localparam int M1 = (GATE_SETUP > PULSE_WIDTH) ? GATE_SETUP : PULSE_WIDTH;
    localparam int M2 = (GATE_HOLD > CONFIRM_TIMEOUT) ? GATE_HOLD : CONFIRM_TIMEOUT;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_TGL = 2'b10;
    localparam logic [1:0] OP_SNS = 2'b11;

    localparam logic [CW-1:0] LD_SETUP = CW'(GATE_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(GATE_HOLD - 1);
    localparam logic [CW-1:0] LD_CONF  = CW'(CONFIRM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CONFIRM,
        REPORT
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    op_q, op_next;
    logic          exp_q, exp_next;
    logic          rdy_q;
    logic          fin_err;
    logic          accept;
    logic          match;
    logic          conflict;
    logic          use_l, use_r;
    logic          in_gate, in_ac;

    assign accept   = cmd_valid && rdy_q;
    assign match    = (trig_b == exp_q) && (trig_p == !trig_b);
    assign conflict = (trig_b == trig_p);

    always_ff @(posedge clk or posedge reset_left) begin
        if (reset_left) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_CLR;
            exp_q <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            op_q  <= op_next;
            exp_q <= exp_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        op_next    = op_q;
        exp_next   = exp_q;
        fin_err    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_next = cmd_op;
                    case (cmd_op)
                        OP_CLR:  exp_next = 1'b0;
                        OP_SET:  exp_next = 1'b1;
                        OP_TGL:  exp_next = !trig_b;
                        default: exp_next = trig_b;
                    endcase
                    if (cmd_op == OP_SNS) begin
                        next_state = CONFIRM;
                        cnt_next   = LD_CONF;
                    end else begin
                        next_state = SETUP;
                        cnt_next   = LD_SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    next_state = PULSE;
                    cnt_next   = LD_PULSE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    next_state = HOLD;
                    cnt_next   = LD_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    next_state = CONFIRM;
                    cnt_next   = LD_CONF;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            CONFIRM: begin
                // b==p can never satisfy match, so it falls to the error arm
                if (match) begin
                    next_state = REPORT;
                    cnt_next   = '0;
                end else if (conflict || cnt == '0) begin
                    next_state = REPORT;
                    cnt_next   = '0;
                    fin_err    = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            REPORT: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are glitch-free flops
    assign use_l   = (op_next == OP_CLR) || (op_next == OP_TGL);
    assign use_r   = (op_next == OP_SET) || (op_next == OP_TGL);
    assign in_gate = (next_state == SETUP) || (next_state == PULSE) ||
                     (next_state == HOLD);
    assign in_ac   = (next_state == PULSE);

    always_ff @(posedge clk or posedge reset_left) begin
        if (reset_left) begin
            rdy_q        <= 1'b0;
            gate_left    <= 1'b0;
            ac_set_left  <= 1'b0;
            gate_right   <= 1'b0;
            ac_set_right <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            state_out    <= 1'b0;
        end else begin
            rdy_q        <= (next_state == IDLE);
            gate_left    <= in_gate && use_l;
            ac_set_left  <= in_ac && use_l;
            gate_right   <= in_gate && use_r;
            ac_set_right <= in_ac && use_r;
            done         <= (next_state == REPORT);
            err          <= (next_state == REPORT) && fin_err;
            state_out    <= (next_state == REPORT) && trig_b;
        end
    end

    assign cmd_ready = rdy_q;

endmodule

// File: tb/tb_sms_trigger_driver.sv
// Self-checking bench for sms_trigger_driver with a behavioural trigger card.
// Table-driven commands, scoreboard of expected results, reset corner case.
module tb_sms_trigger_driver;

    localparam int S  = 2;
    localparam int W  = 3;
    localparam int H  = 1;
    localparam int TO = 4;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_TGL = 2'b10;
    localparam logic [1:0] OP_SNS = 2'b11;

    logic       clk = 1'b0;
    logic       reset_left = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready;
    logic       trig_b, trig_p;
    logic       gate_left, ac_set_left, gate_right, ac_set_right;
    logic       done, err, state_out;

    // trigger card model controls
    logic model_b = 1'b0;
    logic load_b = 1'b0;
    logic load_val = 1'b0;
    logic stuck = 1'b0;
    logic tied = 1'b0;
    logic prev_l = 1'b0;
    logic prev_r = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        bit         load;
        bit         b0;
        bit         stuck;
        bit         tied;
        bit         poke;
        bit         exp_err;
        bit         exp_st;
        int         exp_lat;
    } vec_t;

    typedef struct {
        bit err;
        bit st;
        int lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    sms_trigger_driver #(
        .GATE_SETUP(S),
        .PULSE_WIDTH(W),
        .GATE_HOLD(H),
        .CONFIRM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_left(reset_left),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_ready(cmd_ready),
        .trig_b(trig_b),
        .trig_p(trig_p),
        .gate_left(gate_left),
        .ac_set_left(ac_set_left),
        .gate_right(gate_right),
        .ac_set_right(ac_set_right),
        .done(done),
        .err(err),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign trig_b = tied ? 1'b0 : model_b;
    assign trig_p = tied ? 1'b0 : ~model_b;

    // Trigger acts on the rising edge of a gated AC-set input
    always @(posedge clk) begin
        prev_l <= ac_set_left;
        prev_r <= ac_set_right;
        if (load_b) begin
            model_b <= load_val;
        end else if (!stuck) begin
            if (ac_set_left && !prev_l && gate_left &&
                ac_set_right && !prev_r && gate_right)
                model_b <= ~model_b;
            else if (ac_set_left && !prev_l && gate_left)
                model_b <= 1'b0;
            else if (ac_set_right && !prev_r && gate_right)
                model_b <= 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_model(input bit b);
        @(negedge clk);
        load_val = b;
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) chk("ready_wait", 0, 1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input bit poke);
        int t0, rel;
        int glf, gll, alf, all, grf, grl, arf, arl;
        bit seen, bad_co, use_l, use_r;
        exp_t e;
        glf = -1; gll = -1; alf = -1; all = -1;
        grf = -1; grl = -1; arf = -1; arl = -1;
        seen = 1'b0;
        bad_co = 1'b0;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op = op;
        t0 = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (poke && rel == 3) begin
                cmd_valid = 1'b1;
                cmd_op = OP_SNS;
            end
            if (poke && rel == 4) cmd_valid = 1'b0;
            if (gate_left) begin if (glf < 0) glf = rel; gll = rel; end
            if (ac_set_left) begin if (alf < 0) alf = rel; all = rel; end
            if (gate_right) begin if (grf < 0) grf = rel; grl = rel; end
            if (ac_set_right) begin if (arf < 0) arf = rel; arl = rel; end
            if (gate_left != gate_right || ac_set_left != ac_set_right)
                bad_co = 1'b1;
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("done_latency", rel, e.lat);
                chk("err", err, e.err);
                chk("state_out", state_out, e.st);
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        use_l = (op == OP_CLR) || (op == OP_TGL);
        use_r = (op == OP_SET) || (op == OP_TGL);
        chk("gate_left_first", glf, use_l ? 1 : -1);
        chk("gate_left_last", gll, use_l ? S + W + H : -1);
        chk("ac_left_first", alf, use_l ? 1 + S : -1);
        chk("ac_left_last", all, use_l ? S + W : -1);
        chk("gate_right_first", grf, use_r ? 1 : -1);
        chk("gate_right_last", grl, use_r ? S + W + H : -1);
        chk("ac_right_first", arf, use_r ? 1 + S : -1);
        chk("ac_right_last", arl, use_r ? S + W : -1);
        if (op == OP_TGL) chk("toggle_coincident", bad_co, 0);
        @(negedge clk);
        chk("ready_after_done", cmd_ready, 1);
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("busy_cmd_ignored", {cmd_ready, done, gate_left}, 3'b100);
            end
        end
    endtask

    initial begin
        int t0;
        exp_t e;

        vecs[0] = '{OP_CLR, 1, 1, 0, 0, 0, 0, 0, 8};
        vecs[1] = '{OP_TGL, 1, 0, 0, 0, 1, 0, 1, 8};
        vecs[2] = '{OP_TGL, 0, 0, 0, 0, 0, 0, 0, 8};
        vecs[3] = '{OP_SET, 1, 1, 0, 0, 0, 0, 1, 8};
        vecs[4] = '{OP_SNS, 0, 0, 0, 1, 0, 1, 0, 2};
        vecs[5] = '{OP_CLR, 1, 1, 1, 0, 0, 1, 1, 1 + S + W + H + TO};
        vecs[6] = '{OP_SNS, 1, 0, 0, 0, 0, 0, 0, 2};
        vecs[7] = '{OP_SET, 1, 0, 0, 0, 0, 0, 1, 8};

        #1 reset_left = 1'b1;
        #2;
        chk("reset_outputs",
            {gate_left, ac_set_left, gate_right, ac_set_right,
             done, err, state_out, cmd_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_left = 1'b0;
        #1 chk("ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1 chk("ready_after_release", cmd_ready, 1);

        foreach (vecs[i]) begin
            stuck = vecs[i].stuck;
            tied = vecs[i].tied;
            if (vecs[i].load) set_model(vecs[i].b0);
            e.err = vecs[i].exp_err;
            e.st = vecs[i].exp_st;
            e.lat = vecs[i].exp_lat;
            sb.push_back(e);
            run_cmd(vecs[i].op, vecs[i].poke);
        end
        stuck = 1'b0;
        tied = 1'b0;

        // reset in the middle of a set command
        set_model(1'b0);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op = OP_SET;
        t0 = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 10 && (cyc - t0) < 4; i++) @(negedge clk);
        chk("pre_reset_gate_right", gate_right, 1);
        reset_left = 1'b1;
        #1;
        chk("midcmd_reset_outputs",
            {gate_left, ac_set_left, gate_right, ac_set_right,
             done, err, state_out, cmd_ready}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no_done_in_reset", done, 0);
        end
        reset_left = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_midreset", cmd_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", done, 0);
        end
        e.err = 1'b0;
        e.st = 1'b0;
        e.lat = 8;
        sb.push_back(e);
        run_cmd(OP_CLR, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
